// File: rtl/clock_step_ctrl_pkg.sv
// clock_step_ctrl_pkg: shared CPU stepping constants and FSM state encodings.
package clock_step_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    localparam int DEF_DIV_W = 8;
    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/clock_step_ctrl_en_divider.sv
// en_divider: strobes once every div+1 enabled cycles.
// The period is sampled only on reload, and the phase is held while disabled.
module en_divider #(
    parameter int DIV_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             strobe
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_zero;

    assign w_zero = (r_cnt == '0);
    assign strobe = en && w_zero;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_cnt <= '0;
        else if (en)
            r_cnt <= w_zero ? div : r_cnt - 1'b1;
    end

endmodule

// File: rtl/clock_step_ctrl.sv
// clock_step_ctrl: run/halt/single-step clock-enable generator.
// It also produces divided radix/counter strobes and an enabled-cycle counter.
module clock_step_ctrl
    import clock_step_ctrl_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             run,
    input  logic             halt,
    input  logic             step,
    input  logic [DIV_W-1:0] div_radix,
    input  logic [DIV_W-1:0] div_count,
    output logic             cpu_en,
    output logic             radix_en,
    output logic             count_en,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_cnt
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cycle_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // STEP and the unreachable encoding both fall back to IDLE.
    always_comb begin
        w_next = ST_IDLE;
        cpu_en = 1'b0;
        case (r_state)
            ST_IDLE: w_next = halt ? ST_IDLE : step ? ST_STEP : run ? ST_RUN : ST_IDLE;
            ST_RUN: begin
                w_next = halt ? ST_IDLE : ST_RUN;
                cpu_en = 1'b1;
            end
            ST_STEP: cpu_en = 1'b1;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_cycle_cnt <= '0;
        else if (cpu_en)
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
    end

    en_divider #(.DIV_W(DIV_W)) u_radix_div (
        .CLK    (CLK),
        .RST    (RST),
        .en     (cpu_en),
        .div    (div_radix),
        .strobe (radix_en)
    );

    en_divider #(.DIV_W(DIV_W)) u_count_div (
        .CLK    (CLK),
        .RST    (RST),
        .en     (cpu_en),
        .div    (div_count),
        .strobe (count_en)
    );

    assign state     = r_state;
    assign cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_clock_step_ctrl.sv
// tb_clock_step_ctrl: directed vector table plus multi-cycle corner sequences.
module tb_clock_step_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       run = 1'b0;
    logic       halt = 1'b0;
    logic       step = 1'b0;
    logic [7:0] div_radix = '0;
    logic [7:0] div_count = '0;
    logic       cpu_en, radix_en, count_en;
    logic [1:0] state;
    logic [3:0] cycle_cnt;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       run, halt, step;
        logic [7:0] dr, dc;
        logic [1:0] st;
        logic       cpu, rad, cen;
        logic [3:0] cc;
    } vec_t;

    vec_t vecs[14];

    clock_step_ctrl #(.DIV_W(8), .CNT_W(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .run       (run),
        .halt      (halt),
        .step      (step),
        .div_radix (div_radix),
        .div_count (div_count),
        .cpu_en    (cpu_en),
        .radix_en  (radix_en),
        .count_en  (count_en),
        .state     (state),
        .cycle_cnt (cycle_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        run = 0; halt = 0; step = 0;
        RST = 1;
        #2;
        chk("rst_state", int'(state), 0);
        chk("rst_cpu", int'(cpu_en), 0);
        chk("rst_radix", int'(radix_en), 0);
        chk("rst_count", int'(count_en), 0);
        chk("rst_cyc", int'(cycle_cnt), 0);
        tick;
        RST = 0;
    endtask

    initial begin
        vecs[0]  = '{1,0,0, 3,0, 1,1,1,1, 0};
        vecs[1]  = '{0,0,0, 3,0, 1,1,0,1, 1};
        vecs[2]  = '{0,0,0, 3,0, 1,1,0,1, 2};
        vecs[3]  = '{0,0,0, 3,0, 1,1,0,1, 3};
        vecs[4]  = '{0,0,0, 3,0, 1,1,1,1, 4};
        vecs[5]  = '{0,0,0, 3,0, 1,1,0,1, 5};
        vecs[6]  = '{0,0,0, 3,0, 1,1,0,1, 6};
        vecs[7]  = '{0,0,0, 3,0, 1,1,0,1, 7};
        vecs[8]  = '{0,0,0, 3,0, 1,1,1,1, 8};
        vecs[9]  = '{0,1,0, 3,0, 0,0,0,0, 9};
        vecs[10] = '{1,1,1, 3,0, 0,0,0,0, 9};
        vecs[11] = '{1,0,1, 3,0, 2,1,0,1, 9};
        vecs[12] = '{1,0,0, 3,0, 0,0,0,0, 10};
        vecs[13] = '{0,0,0, 3,0, 0,0,0,0, 10};

        // run / halt / priority table
        #1;
        do_reset;
        for (int i = 0; i < 14; i++) begin
            run = vecs[i].run; halt = vecs[i].halt; step = vecs[i].step;
            div_radix = vecs[i].dr; div_count = vecs[i].dc;
            tick;
            chk($sformatf("v%0d_state", i), int'(state), int'(vecs[i].st));
            chk($sformatf("v%0d_cpu", i), int'(cpu_en), int'(vecs[i].cpu));
            chk($sformatf("v%0d_radix", i), int'(radix_en), int'(vecs[i].rad));
            chk($sformatf("v%0d_count", i), int'(count_en), int'(vecs[i].cen));
            chk($sformatf("v%0d_cyc", i), int'(cycle_cnt), int'(vecs[i].cc));
        end
        run = 0; halt = 0; step = 0;

        // three step pulses, 4 cycles apart, div_radix=1
        do_reset;
        div_radix = 1; div_count = 0;
        for (int p = 0; p < 3; p++) begin
            step = 1;
            tick;
            step = 0;
            chk($sformatf("stp%0d_state", p), int'(state), 2);
            chk($sformatf("stp%0d_cpu", p), int'(cpu_en), 1);
            chk($sformatf("stp%0d_radix", p), int'(radix_en), (p != 1) ? 1 : 0);
            tick;
            chk($sformatf("stp%0d_idle", p), int'(state), 0);
            chk($sformatf("stp%0d_cpu_off", p), int'(cpu_en), 0);
            tick;
            tick;
            chk($sformatf("stp%0d_cpu_gap", p), int'(cpu_en), 0);
        end
        chk("stp_cyc", int'(cycle_cnt), 3);

        // div_radix 2 -> 5 mid-period: strobes at enabled cycles 1,4,7,13,19
        do_reset;
        div_radix = 2; div_count = 0;
        run = 1;
        for (int i = 1; i <= 20; i++) begin
            tick;
            run = 0;
            chk($sformatf("chg%0d_radix", i), int'(radix_en),
                (i == 1 || i == 4 || i == 7 || i == 13 || i == 19) ? 1 : 0);
            if (i == 5) div_radix = 5;
        end
        halt = 1;
        tick;
        halt = 0;

        // cycle_cnt wrap with CNT_W=4
        do_reset;
        div_radix = 0; div_count = 0;
        run = 1;
        for (int i = 1; i <= 17; i++) begin
            tick;
            run = 0;
            chk($sformatf("wrap%0d_cyc", i), int'(cycle_cnt), (i - 1) % 16);
        end
        halt = 1;
        tick;
        halt = 0;
        chk("wrap_final", int'(cycle_cnt), 1);
        chk("wrap_state", int'(state), 0);

        // async reset mid-RUN, then first enabled cycle strobes both
        do_reset;
        div_radix = 3; div_count = 2;
        run = 1;
        tick;
        run = 0;
        chk("ar_radix1", int'(radix_en), 1);
        tick;
        tick;
        chk("ar_pre_cpu", int'(cpu_en), 1);
        chk("ar_pre_cyc", int'(cycle_cnt), 2);
        #2;
        RST = 1;
        #1;
        chk("ar_cpu", int'(cpu_en), 0);
        chk("ar_radix", int'(radix_en), 0);
        chk("ar_count", int'(count_en), 0);
        chk("ar_cyc", int'(cycle_cnt), 0);
        chk("ar_state", int'(state), 0);
        tick;
        RST = 0;
        run = 1;
        tick;
        run = 0;
        chk("ar_post_state", int'(state), 1);
        chk("ar_post_radix", int'(radix_en), 1);
        chk("ar_post_count", int'(count_en), 1);
        chk("ar_post_cyc", int'(cycle_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
